// File: rtl/clock_pkg.sv
// Shared mode encodings and BCD constants for the time-of-day counter.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2
  } mode_e;

  localparam logic [7:0] BCD_59   = 8'h59;
  localparam logic [7:0] BCD_ZERO = 8'h00;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD modulo counter. Counts 00 .. MOD-1 directly in BCD
// and flags the wrap combinationally so the next field can carry on the
// same edge.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] o_value,
  output logic       o_wrap
);

  localparam logic [3:0] MAX_TENS = 4'((MOD - 1) / 10);
  localparam logic [3:0] MAX_ONES = 4'((MOD - 1) % 10);
  localparam logic [7:0] MAX_BCD  = {MAX_TENS, MAX_ONES};

  logic [7:0] r_val;
  logic       w_at_max;

  assign w_at_max = (r_val == MAX_BCD);
  assign o_wrap   = inc & w_at_max;
  assign o_value  = r_val;

  // BCD increment: ones wrap 9->0 with carry into tens, whole field wraps at MOD-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val <= BCD_ZERO;
    end else if (clr) begin
      r_val <= BCD_ZERO;
    end else if (inc) begin
      if (w_at_max) begin
        r_val <= BCD_ZERO;
      end else if (r_val[3:0] == 4'd9) begin
        r_val <= {r_val[7:4] + 4'd1, 4'd0};
      end else begin
        r_val <= {r_val[7:4], r_val[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/clock_hms_counter.sv
// Hours/minutes/seconds BCD time-of-day counter with a RUN / SET_H / SET_M
// set mode driven by two single-cycle button pulses.
module clock_hms_counter
  import clock_pkg::*;
#(
  parameter int HOUR_MOD = 24
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       blink,
  output logic       day_pulse
);

  mode_e r_mode;
  mode_e w_mode_nxt;
  logic  r_armed;
  logic  r_blink;
  logic  r_day;
  logic  w_blink_nxt;

  logic  w_tick;
  logic  w_run;
  logic  w_set_h;
  logic  w_set_m;
  logic  w_sec_inc;
  logic  w_min_inc;
  logic  w_hour_inc;
  logic  w_sec_wrap;
  logic  w_min_wrap;
  logic  w_hour_wrap;

  // The divider holds its tick high through reset, so the first post-reset
  // tick is discarded until the arm flag is set.
  assign w_tick  = tick_1s & r_armed;
  assign w_run   = (r_mode == MODE_RUN);
  assign w_set_h = (r_mode == MODE_SET_H);
  assign w_set_m = (r_mode == MODE_SET_M);

  // A mode change always wins: it drops any tick or inc on the same edge.
  assign w_sec_inc  = w_run & ~btn_mode & w_tick;
  assign w_min_inc  = w_run ? w_sec_wrap : (w_set_m & ~btn_mode & btn_inc);
  assign w_hour_inc = w_run ? w_min_wrap : (w_set_h & ~btn_mode & btn_inc);

  // Arm flag: set on the first edge after reset release
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) r_armed <= 1'b0;
    else      r_armed <= 1'b1;
  end

  // Mode state register
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) r_mode <= MODE_RUN;
    else      r_mode <= w_mode_nxt;
  end

  // Next mode and next blink; encoding 3 falls into default and recovers to RUN
  always_comb begin
    w_mode_nxt  = MODE_RUN;
    w_blink_nxt = 1'b0;
    case (r_mode)
      MODE_RUN: begin
        w_mode_nxt = btn_mode ? MODE_SET_H : MODE_RUN;
      end
      MODE_SET_H: begin
        w_mode_nxt = btn_mode ? MODE_SET_M : MODE_SET_H;
        if (!btn_mode) w_blink_nxt = r_blink ^ w_tick;
      end
      MODE_SET_M: begin
        w_mode_nxt = btn_mode ? MODE_RUN : MODE_SET_M;
        if (!btn_mode) w_blink_nxt = r_blink ^ w_tick;
      end
      default: begin
        w_mode_nxt = MODE_RUN;
      end
    endcase
  end

  // Blink and day pulse registers; day pulse only from a RUN-mode carry
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_blink <= 1'b0;
      r_day   <= 1'b0;
    end else begin
      r_blink <= w_blink_nxt;
      r_day   <= w_run & w_hour_wrap;
    end
  end

  // Seconds restart from 00 on every mode change
  bcd_mod_counter #(.MOD(60)) u_sec (
    .clk     (clk_50MHz),
    .rst     (rst),
    .inc     (w_sec_inc),
    .clr     (btn_mode),
    .o_value (sec_bcd),
    .o_wrap  (w_sec_wrap)
  );

  bcd_mod_counter #(.MOD(60)) u_min (
    .clk     (clk_50MHz),
    .rst     (rst),
    .inc     (w_min_inc),
    .clr     (1'b0),
    .o_value (min_bcd),
    .o_wrap  (w_min_wrap)
  );

  bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
    .clk     (clk_50MHz),
    .rst     (rst),
    .inc     (w_hour_inc),
    .clr     (1'b0),
    .o_value (hour_bcd),
    .o_wrap  (w_hour_wrap)
  );

  assign mode      = r_mode;
  assign blink     = r_blink;
  assign day_pulse = r_day;

endmodule

// File: tb/tb_clock_hms_counter.sv
// Bench for clock_hms_counter: table vectors plus a model-fed scoreboard
// for the 24-hour instance, and hand checks on a 12-hour instance.
module tb_clock_hms_counter;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       bm;
  logic       bi;
  logic [7:0] h24, m24, s24, h12, m12, s12;
  logic [1:0] md24, md12;
  logic       bl24, bl12, dp24, dp12;

  int checks;
  int errors;

  clock_hms_counter #(.HOUR_MOD(24)) u_dut24 (
    .clk_50MHz (clk), .rst (rst_n), .tick_1s (tick), .btn_mode (bm), .btn_inc (bi),
    .hour_bcd (h24), .min_bcd (m24), .sec_bcd (s24), .mode (md24), .blink (bl24),
    .day_pulse (dp24)
  );

  clock_hms_counter #(.HOUR_MOD(12)) u_dut12 (
    .clk_50MHz (clk), .rst (rst_n), .tick_1s (tick), .btn_mode (bm), .btn_inc (bi),
    .hour_bcd (h12), .min_bcd (m12), .sec_bcd (s12), .mode (md12), .blink (bl12),
    .day_pulse (dp12)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model of the 24-hour instance ----------------
  int m_h, m_m, m_s, m_mode;
  bit m_blink, m_day, m_armed;

  function automatic logic [7:0] to_bcd(int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [27:0] model_pack();
    return {2'(m_mode), to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), m_blink, m_day};
  endfunction

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0;
    m_blink = 0; m_day = 0; m_armed = 0;
  endtask

  task automatic model_step(bit b_mode, bit b_inc, bit t);
    bit tk;
    tk = m_armed ? t : 1'b0;
    m_armed = 1;
    m_day = 0;
    if (b_mode) begin
      m_mode  = (m_mode == 0) ? 1 : (m_mode == 1) ? 2 : 0;
      m_s     = 0;
      m_blink = 0;
    end else if (m_mode == 0) begin
      if (tk) begin
        m_s = m_s + 1;
        if (m_s == 60) begin
          m_s = 0; m_m = m_m + 1;
          if (m_m == 60) begin
            m_m = 0; m_h = m_h + 1;
            if (m_h == 24) begin m_h = 0; m_day = 1; end
          end
        end
      end
    end else begin
      if (b_inc && m_mode == 1) m_h = (m_h + 1) % 24;
      if (b_inc && m_mode == 2) m_m = (m_m + 1) % 60;
      if (tk) m_blink = ~m_blink;
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [27:0] v;
  } exp_t;

  exp_t  exp_q[$];
  string cur_name;

  initial begin
    exp_t        e;
    logic [27:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {md24, h24, m24, s24, bl24, dp24};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got %h required %h (mode,h,m,s,blink,day)", e.name, act, e.v);
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  task automatic push_cur();
    exp_t e;
    model_step(bm, bi, tick);
    e.name = cur_name;
    e.v    = model_pack();
    exp_q.push_back(e);
  endtask

  task automatic cyc(bit b_mode, bit b_inc, bit t);
    @(negedge clk);
    bm = b_mode; bi = b_inc; tick = t;
    push_cur();
  endtask

  task automatic tick_n(int n);
    for (int k = 0; k < n; k++) begin
      cyc(0, 0, 1);
      cyc(0, 0, 0);
    end
  endtask

  task automatic inc_n(int n);
    for (int k = 0; k < n; k++) cyc(0, 1, 0);
  endtask

  // Hold reset for two cycles with the given tick level, release at a negedge;
  // the first edge after release sees the held inputs.
  task automatic do_reset(bit tick_hold);
    @(negedge clk);
    rst_n = 0; bm = 0; bi = 0; tick = tick_hold;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    push_cur();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic       m, i, t;
    logic [1:0] mode;
    logic [7:0] h, mi, s;
    logic       bl, day;
  } vec_t;

  vec_t tbl[14];

  initial begin
    exp_t e;
    checks = 0; errors = 0;
    rst_n = 1; bm = 0; bi = 0; tick = 0;
    model_reset();

    // Rows continue from 00:00:03 RUN
    tbl[0]  = '{0,0,1, 2'd0, 8'h00, 8'h00, 8'h04, 0, 0};
    tbl[1]  = '{0,0,1, 2'd0, 8'h00, 8'h00, 8'h05, 0, 0};
    tbl[2]  = '{0,1,0, 2'd0, 8'h00, 8'h00, 8'h05, 0, 0};
    tbl[3]  = '{1,0,0, 2'd1, 8'h00, 8'h00, 8'h00, 0, 0};
    tbl[4]  = '{0,1,1, 2'd1, 8'h01, 8'h00, 8'h00, 1, 0};
    tbl[5]  = '{0,1,0, 2'd1, 8'h02, 8'h00, 8'h00, 1, 0};
    tbl[6]  = '{0,0,1, 2'd1, 8'h02, 8'h00, 8'h00, 0, 0};
    tbl[7]  = '{0,0,1, 2'd1, 8'h02, 8'h00, 8'h00, 1, 0};
    tbl[8]  = '{1,1,0, 2'd2, 8'h02, 8'h00, 8'h00, 0, 0};
    tbl[9]  = '{0,1,0, 2'd2, 8'h02, 8'h01, 8'h00, 0, 0};
    tbl[10] = '{0,1,1, 2'd2, 8'h02, 8'h02, 8'h00, 1, 0};
    tbl[11] = '{1,0,1, 2'd0, 8'h02, 8'h02, 8'h00, 0, 0};
    tbl[12] = '{0,0,1, 2'd0, 8'h02, 8'h02, 8'h01, 0, 0};
    tbl[13] = '{0,0,0, 2'd0, 8'h02, 8'h02, 8'h01, 0, 0};

    // Reset values, checked while reset is held
    @(negedge clk);
    rst_n = 0; tick = 1;
    #1;
    check("reset_state", {22'd0, md24, h24, m24, s24, bl24, dp24},
          {22'd0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});

    // Arm flag: tick held across reset release is discarded
    cur_name = "arm";
    do_reset(1);
    cyc(0, 0, 0);
    tick_n(3);
    @(posedge clk); #1;
    check("arm_sec", {24'd0, s24}, 32'h03);

    // Table vectors
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      bm = tbl[k].m; bi = tbl[k].i; tick = tbl[k].t;
      model_step(bm, bi, tick);
      e.name = $sformatf("tbl%0d", k);
      e.v    = {tbl[k].mode, tbl[k].h, tbl[k].mi, tbl[k].s, tbl[k].bl, tbl[k].day};
      exp_q.push_back(e);
    end

    // mode + tick in RUN at sec 37
    cur_name = "run_to_37";
    tick_n(36);
    @(posedge clk); #1;
    check("sec_37", {24'd0, s24}, 32'h37);
    cur_name = "mode_tick_run";
    cyc(1, 0, 1);
    @(posedge clk); #1;
    check("mode_tick_run", {22'd0, md24, s24}, {22'd0, 2'd1, 8'h00});
    cyc(1, 0, 0);
    cyc(1, 0, 0);

    // Set-mode wraps with ticks interleaved
    do_reset(0);
    cur_name = "seth_wrap";
    cyc(1, 0, 0);
    for (int k = 0; k < 24; k++) cyc(0, 1, (k % 4) == 0);
    @(posedge clk); #1;
    check("seth_wrap", {16'd0, h24, m24}, 32'h0000);
    cur_name = "setm_wrap";
    cyc(1, 0, 0);
    for (int k = 0; k < 61; k++) cyc(0, 1, (k % 5) == 0);
    @(posedge clk); #1;
    check("setm_wrap", {16'd0, h24, m24}, 32'h0001);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(1, 0, 0);

    // Day rollover: set 23:59, run to 23:59:59, one more tick
    cur_name = "day_set";
    cyc(1, 0, 0);
    inc_n(23);
    cyc(1, 0, 0);
    inc_n(58);
    cyc(1, 0, 0);
    cur_name = "day_run";
    tick_n(59);
    @(posedge clk); #1;
    check("pre_day", {8'd0, h24, m24, s24}, 32'h00235959);
    cur_name = "day_roll";
    cyc(0, 0, 1);
    @(posedge clk); #1;
    check("day_roll", {7'd0, h24, m24, s24, dp24}, {7'd0, 24'h000000, 1'b1});
    cyc(0, 0, 0);
    @(posedge clk); #1;
    check("day_pulse_end", {31'd0, dp24}, 32'd0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);

    // Async reset mid-carry at 12:59:59
    do_reset(0);
    cur_name = "async_setup";
    cyc(1, 0, 0);
    inc_n(12);
    cyc(1, 0, 0);
    inc_n(59);
    cyc(1, 0, 0);
    tick_n(59);
    @(posedge clk); #1;
    check("pre_async", {8'd0, h24, m24, s24}, 32'h00125959);
    @(negedge clk);
    tick = 1;
    #3 rst_n = 0;
    #1;
    check("async_rst", {5'd0, md24, h24, m24, s24, dp24}, 32'd0);
    @(posedge clk); #1;
    check("async_hold", {5'd0, md24, h24, m24, s24, dp24}, 32'd0);

    // 12-hour modulus on the second instance
    do_reset(0);
    cur_name = "h12_setup";
    cyc(1, 0, 0);
    inc_n(11);
    cyc(1, 0, 0);
    inc_n(59);
    cyc(1, 0, 0);
    tick_n(59);
    @(posedge clk); #1;
    check("h12_pre", {8'd0, h12, m12, s12}, 32'h00115959);
    cur_name = "h12_roll";
    cyc(0, 0, 1);
    @(posedge clk); #1;
    check("h12_roll", {7'd0, h12, m12, s12, dp12}, {7'd0, 24'h000000, 1'b1});
    check("h24_no_roll", {7'd0, h24, m24, s24, dp24}, {7'd0, 24'h120000, 1'b0});
    cyc(0, 0, 0);
    @(posedge clk); #1;
    check("h12_pulse_end", {31'd0, dp12}, 32'd0);

    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
